// File: rtl/seg7_pkg.sv
// Shared constants, types and the hex-to-segment lookup for the seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = hex_to_seg(i_nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with per-slot blanking, double-buffered values
// and leading-zero suppression. All pin outputs are registered and active-low.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int BLANK_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam logic [PRESCALE_W-1:0] BLANK_LIM = BLANK_CYC[PRESCALE_W-1:0];

  logic [PRESCALE_W-1:0] r_cnt;
  digit_idx_t            r_idx;
  logic [15:0]           r_shadow_dig;
  logic [3:0]            r_shadow_dp;
  logic [15:0]           r_active_dig;
  logic [3:0]            r_active_dp;
  logic                  r_pending;
  logic [3:0]            r_an_n;
  logic [6:0]            r_seg_n;
  logic                  r_dp_n;
  logic                  r_frame_start;

  logic                  w_wrap;
  logic                  w_commit;
  slot_phase_t           w_phase;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg_n;
  logic [3:0]            w_empty;
  logic [3:0]            w_lz_blank;
  logic                  w_digit_blank;

  assign w_wrap   = &r_cnt;
  assign w_commit = (r_idx == 2'd3) && w_wrap;
  assign w_phase  = (r_cnt < BLANK_LIM) ? PH_BLANK : PH_DRIVE;
  assign w_nib    = r_active_dig[{r_idx, 2'b00} +: 4];

  // A digit is "empty" when its nibble is zero and its dp is dark; blanking only
  // propagates downward through a contiguous run of empty digits from the top.
  always_comb begin
    w_empty = '0;
    for (int k = 0; k < 4; k++) begin
      w_empty[k] = (r_active_dig[4*k +: 4] == 4'h0) && !r_active_dp[k];
    end
  end

  assign w_lz_blank[3]  = lz_en & w_empty[3];
  assign w_lz_blank[2]  = w_lz_blank[3] & w_empty[2];
  assign w_lz_blank[1]  = w_lz_blank[2] & w_empty[1];
  assign w_lz_blank[0]  = 1'b0;
  assign w_digit_blank  = w_lz_blank[r_idx];

  seg7_hex_decode u_dec (
    .i_nib   (w_nib),
    .o_seg_n (w_seg_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) r_idx <= r_idx + 2'd1;
    end
  end

  // Frame-boundary commit; a load landing on the commit cycle bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_active_dig <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
    end else if (load && w_commit) begin
      r_shadow_dig <= digits_in;
      r_shadow_dp  <= dp_in;
      r_active_dig <= digits_in;
      r_active_dp  <= dp_in;
      r_pending    <= 1'b0;
    end else if (load) begin
      r_shadow_dig <= digits_in;
      r_shadow_dp  <= dp_in;
      r_pending    <= 1'b1;
    end else if (w_commit && r_pending) begin
      r_active_dig <= r_shadow_dig;
      r_active_dp  <= r_shadow_dp;
      r_pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n        <= AN_OFF;
      r_seg_n       <= SEG_BLANK;
      r_dp_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= (r_idx == 2'd0) && (r_cnt == '0);
      if (w_phase == PH_BLANK) begin
        r_an_n  <= AN_OFF;
        r_seg_n <= SEG_BLANK;
        r_dp_n  <= 1'b1;
      end else begin
        r_an_n  <= ~(4'b0001 << r_idx);
        r_seg_n <= w_digit_blank ? SEG_BLANK : w_seg_n;
        r_dp_n  <= w_digit_blank ? 1'b1 : ~r_active_dp[r_idx];
      end
    end
  end

  assign an_n        = r_an_n;
  assign seg_n       = r_seg_n;
  assign dp_n        = r_dp_n;
  assign frame_start = r_frame_start;

endmodule
